// File: rtl/vgafb_line_prefetch.sv
// Framebuffer prefetch stage for the VGA scanner. Words are fetched over a strobe/ack
// bus into a ring that runs ahead of dispAddr, and bytes are served with one cycle of latency.
module vgafb_line_prefetch #(
  parameter int RING_LOG2   = 6,
  parameter int AHEAD_WORDS = 40,
  parameter int FB_WORDS    = 1024
) (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        frame_sync,
  input  logic [27:0] fb_base,
  input  logic [15:0] dispAddr,
  output logic [7:0]  dispData,
  output logic [27:0] bus_addr,
  output logic        bus_strobe,
  input  logic        bus_ack,
  input  logic [31:0] bus_data_in,
  output logic        underrun,
  output logic        dbg_state,
  output logic [10:0] dbg_wcnt
);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  localparam int RING_WORDS = 1 << RING_LOG2;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [10:0] r_wcnt;
  logic [27:0] r_base;
  logic        r_restart_pend;
  logic [7:0]  r_disp_data;
  logic [27:0] r_bus_addr;
  logic        r_bus_strobe;
  logic        r_underrun;
  logic [31:0] r_ring [RING_WORDS];

  logic [13:0] w_dword;
  logic [15:0] w_dword16;
  logic [15:0] w_wcnt16;
  logic [15:0] w_lead;
  logic        w_behind;
  logic        w_lead_ok;
  logic        w_wcnt_open;
  logic        w_dword_in_fb;
  logic        w_under_set;
  logic        w_fetch;
  logic        w_restart;
  logic        w_take;
  logic [31:0] w_rd_word;
  logic [7:0]  w_rd_byte;

  assign w_dword       = dispAddr[15:2];
  assign w_dword16     = {2'b00, w_dword};
  assign w_wcnt16      = {5'b00000, r_wcnt};
  assign w_lead        = w_wcnt16 - w_dword16;
  assign w_behind      = (w_dword16 >= w_wcnt16);
  assign w_lead_ok     = (w_lead < 16'(AHEAD_WORDS));
  assign w_wcnt_open   = (r_wcnt < 11'(FB_WORDS));
  assign w_dword_in_fb = (w_dword16 < 16'(FB_WORDS));
  // Scanner positions past the end of the frame never count as an underrun.
  assign w_under_set   = enable & w_behind & w_wcnt_open & w_dword_in_fb;
  assign w_rd_word     = r_ring[w_dword[RING_LOG2-1:0]];
  assign w_rd_byte     = w_rd_word[{dispAddr[1:0], 3'b000} +: 8];

  // Bus handshake: strobe rises with a stable bus_addr; the word transfers on the edge
  // where bus_ack is high while strobe is high, and strobe falls on that same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_fetch     = 1'b0;
    w_restart   = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_restart_pend) begin
          w_restart = 1'b1;
        end else if (enable && w_wcnt_open && (w_behind || w_lead_ok)) begin
          w_fetch     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (bus_ack) begin
          w_take      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_wcnt         <= 11'd0;
      r_base         <= 28'd0;
      r_restart_pend <= 1'b0;
      r_disp_data    <= 8'd0;
      r_bus_addr     <= 28'd0;
      r_bus_strobe   <= 1'b0;
      r_underrun     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_fetch) begin
        r_bus_addr   <= r_base + 28'(r_wcnt);
        r_bus_strobe <= 1'b1;
      end else if (w_take) begin
        r_bus_strobe <= 1'b0;
      end

      if (w_restart) begin
        r_wcnt <= 11'd0;
        r_base <= fb_base;
      end else if (w_take) begin
        r_wcnt <= r_wcnt + 11'd1;
      end

      // A sync seen while a restart is already pending is absorbed by that restart.
      if (w_restart) begin
        r_restart_pend <= 1'b0;
      end else if (frame_sync) begin
        r_restart_pend <= 1'b1;
      end

      if (w_restart) begin
        r_underrun <= 1'b0;
      end else if (w_under_set) begin
        r_underrun <= 1'b1;
      end

      if (enable && !w_behind) begin
        r_disp_data <= w_rd_byte;
      end else begin
        r_disp_data <= 8'd0;
      end
    end
  end

  // Ring storage has no reset; only slots below wcnt are ever read.
  always_ff @(posedge clk_pixel) begin
    if (w_take) begin
      r_ring[r_wcnt[RING_LOG2-1:0]] <= bus_data_in;
    end
  end

  assign dispData   = r_disp_data;
  assign bus_addr   = r_bus_addr;
  assign bus_strobe = r_bus_strobe;
  assign underrun   = r_underrun;
  assign dbg_state  = r_state;
  assign dbg_wcnt   = r_wcnt;

endmodule
